// File: rtl/execute_stage_pkg.sv
// Shared widths, ALU opcodes, FSM encoding and the latched memory request for the execute stage.
package execute_stage_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned ALU_OP_W  = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND   = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR    = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR   = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SHL   = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SHR   = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA   = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_PASSB = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_SLT   = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU  = 4'd10;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_MEM = 1'b1
  } state_e;

  // Access captured when a load/store leaves RUN; held stable for the whole MEM phase
  typedef struct packed {
    logic                 we;
    logic                 wb_en;
    logic [REG_IDX_W-1:0] dest;
    logic [XLEN-1:0]      addr;
    logic [XLEN-1:0]      wdata;
  } mem_req_t;

endpackage

// File: rtl/exec_regfile.sv
// 32x32 register file, two combinational read ports, one write port; r0 is hardwired to zero.
module exec_regfile
  import execute_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] raddr1,
  input  logic [REG_IDX_W-1:0] raddr2,
  output logic [XLEN-1:0]      rdata1,
  output logic [XLEN-1:0]      rdata2,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [XLEN-1:0]      wdata
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata1 = regs_q[raddr1];
  assign rdata2 = regs_q[raddr2];

endmodule

// File: rtl/execute_stage.sv
// Execute/writeback stage: ALU, register file access, req/ack memory port and jump/CALL/RET resolution.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned PC_STEP      = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ALU_OP_W-1:0]  ctl_alu_op,
  input  logic [REG_IDX_W-1:0] ctl_alu_src1,
  input  logic [REG_IDX_W-1:0] ctl_alu_src2,
  input  logic [REG_IDX_W-1:0] ctl_alu_dest,
  input  logic                 ctl_reg_write_enable,
  input  logic                 ctl_imm,
  input  logic [XLEN-1:0]      ctl_imm_val,
  input  logic                 ctl_load_pc,
  input  logic [XLEN-1:0]      ctl_load_pc_val,
  input  logic                 ctl_alu_next_enable,
  input  logic                 ctl_mem_rd,
  input  logic                 ctl_mem_wr,
  input  logic                 ctl_mem_data_in,
  input  logic                 ctl_pc_next_enable,
  input  logic [XLEN-1:0]      pc_in,
  input  logic [XLEN-1:0]      mem_rdata,
  input  logic                 mem_ack,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [XLEN-1:0]      mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  output logic                 stall,
  output logic                 flush,
  output logic                 pc_load,
  output logic [XLEN-1:0]      pc_load_val,
  output logic                 wb_valid,
  output logic [REG_IDX_W-1:0] wb_dest,
  output logic [XLEN-1:0]      wb_data
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;
  mem_req_t             mreq_q, mreq_d;
  logic                 mem_req_q, mem_req_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [REG_IDX_W-1:0] wb_dest_q, wb_dest_d;
  logic [XLEN-1:0]      wb_data_q, wb_data_d;

  logic [XLEN-1:0]      rs1_data, rs2_data, op_b, alu_res, link, addr_sum;
  logic                 rf_we;
  logic [REG_IDX_W-1:0] rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic                 squash, is_mem;

  // Load writeback always takes mem_rdata, so the explicit source select carries no extra information
  logic unused_mem_data_in;
  assign unused_mem_data_in = ctl_mem_data_in;

  exec_regfile u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (ctl_alu_src1),
    .raddr2 (ctl_alu_src2),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata)
  );

  assign op_b     = ctl_imm ? ctl_imm_val : rs2_data;
  assign link     = pc_in + XLEN'(PC_STEP);
  assign addr_sum = rs1_data + op_b;
  assign squash   = (flush_cnt_q != '0);
  assign is_mem   = ctl_mem_rd | ctl_mem_wr;

  always_comb begin
    alu_res = '0;
    case (ctl_alu_op)
      ALU_ADD:   alu_res = rs1_data + op_b;
      ALU_SUB:   alu_res = rs1_data - op_b;
      ALU_AND:   alu_res = rs1_data & op_b;
      ALU_OR:    alu_res = rs1_data | op_b;
      ALU_XOR:   alu_res = rs1_data ^ op_b;
      ALU_SHL:   alu_res = rs1_data << op_b[4:0];
      ALU_SHR:   alu_res = rs1_data >> op_b[4:0];
      ALU_SRA:   alu_res = $unsigned($signed(rs1_data) >>> op_b[4:0]);
      ALU_PASSB: alu_res = op_b;
      ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1_data) < $signed(op_b))};
      ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (rs1_data < op_b)};
      default:   alu_res = '0;
    endcase
  end

  // Next-state, register-file write and upstream control
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = squash ? flush_cnt_q - CNT_W'(1) : flush_cnt_q;
    mreq_d      = mreq_q;
    mem_req_d   = mem_req_q;
    rf_we       = 1'b0;
    rf_waddr    = ctl_alu_dest;
    rf_wdata    = ctl_pc_next_enable ? link : alu_res;
    stall       = 1'b0;
    flush       = squash;
    pc_load     = 1'b0;
    pc_load_val = '0;

    case (state_q)
      ST_RUN: begin
        if (!squash) begin
          if (is_mem) begin
            stall        = 1'b1;
            mreq_d.we    = ctl_mem_wr;
            mreq_d.wb_en = ctl_mem_rd & ~ctl_mem_wr & ctl_reg_write_enable;
            mreq_d.dest  = ctl_alu_dest;
            mreq_d.addr  = addr_sum;
            mreq_d.wdata = rs2_data;
            mem_req_d    = 1'b1;
            state_d      = ST_MEM;
          end else begin
            rf_we = ctl_reg_write_enable;
            if (ctl_load_pc) begin
              pc_load     = 1'b1;
              flush       = 1'b1;
              pc_load_val = ctl_alu_next_enable ? rs1_data : ctl_load_pc_val;
              flush_cnt_d = CNT_W'(FLUSH_CYCLES - 1);
            end
          end
        end
      end
      ST_MEM: begin
        stall = ~mem_ack;
        if (mem_ack) begin
          rf_we     = mreq_q.wb_en;
          rf_waddr  = mreq_q.dest;
          rf_wdata  = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    wb_valid_d = rf_we & (rf_waddr != '0);
    wb_dest_d  = wb_valid_d ? rf_waddr : wb_dest_q;
    wb_data_d  = wb_valid_d ? rf_wdata : wb_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      mreq_q      <= '0;
      mem_req_q   <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_dest_q   <= '0;
      wb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      mreq_q      <= mreq_d;
      mem_req_q   <= mem_req_d;
      wb_valid_q  <= wb_valid_d;
      wb_dest_q   <= wb_dest_d;
      wb_data_q   <= wb_data_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mreq_q.we;
  assign mem_addr  = mreq_q.addr;
  assign mem_wdata = mreq_q.wdata;
  assign wb_valid  = wb_valid_q;
  assign wb_dest   = wb_dest_q;
  assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_execute_stage.sv
// Randomized self-checking bench for execute_stage against an instruction-level reference model.
module tb_execute_stage;

  localparam int unsigned FLUSH_CYCLES = 2;

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  s1, s2, d;
    logic        we, imm;
    logic [31:0] immv;
    logic        lpc;
    logic [31:0] lpcv;
    logic        nxt, rd, wr, din, pcn;
    logic [31:0] pc;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ctl_alu_op;
  logic [4:0]  ctl_alu_src1, ctl_alu_src2, ctl_alu_dest;
  logic        ctl_reg_write_enable, ctl_imm, ctl_load_pc, ctl_alu_next_enable;
  logic [31:0] ctl_imm_val, ctl_load_pc_val, pc_in, mem_rdata;
  logic        ctl_mem_rd, ctl_mem_wr, ctl_mem_data_in, ctl_pc_next_enable, mem_ack;
  logic        mem_req, mem_we, stall, flush, pc_load, wb_valid;
  logic [31:0] mem_addr, mem_wdata, pc_load_val, wb_data;
  logic [4:0]  wb_dest;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] regs_m [32];
  int unsigned squash_left;
  logic [31:0] obs_wb_data, obs_pcl_val, obs_mem_addr;
  logic [4:0]  obs_wb_dest;
  logic        obs_wb_valid;

  always #5 clk = ~clk;

  execute_stage #(.FLUSH_CYCLES(FLUSH_CYCLES), .PC_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .ctl_alu_op(ctl_alu_op), .ctl_alu_src1(ctl_alu_src1), .ctl_alu_src2(ctl_alu_src2),
    .ctl_alu_dest(ctl_alu_dest), .ctl_reg_write_enable(ctl_reg_write_enable),
    .ctl_imm(ctl_imm), .ctl_imm_val(ctl_imm_val), .ctl_load_pc(ctl_load_pc),
    .ctl_load_pc_val(ctl_load_pc_val), .ctl_alu_next_enable(ctl_alu_next_enable),
    .ctl_mem_rd(ctl_mem_rd), .ctl_mem_wr(ctl_mem_wr), .ctl_mem_data_in(ctl_mem_data_in),
    .ctl_pc_next_enable(ctl_pc_next_enable), .pc_in(pc_in), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .stall(stall), .flush(flush), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = int'(b % 32);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return a[31] ? ~((~a) >> sh) : (a >> sh);
      4'd8:  return b;
      4'd9:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd10: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input instr_t i);
    ctl_alu_op = i.op; ctl_alu_src1 = i.s1; ctl_alu_src2 = i.s2; ctl_alu_dest = i.d;
    ctl_reg_write_enable = i.we; ctl_imm = i.imm; ctl_imm_val = i.immv;
    ctl_load_pc = i.lpc; ctl_load_pc_val = i.lpcv; ctl_alu_next_enable = i.nxt;
    ctl_mem_rd = i.rd; ctl_mem_wr = i.wr; ctl_mem_data_in = i.din;
    ctl_pc_next_enable = i.pcn; pc_in = i.pc;
  endtask

  function automatic instr_t mk_alu(input logic [3:0] op, input logic [4:0] d, input logic [4:0] s1,
                                    input logic [4:0] s2, input logic imm, input logic [31:0] immv);
    instr_t i;
    i = '0;
    i.op = op; i.d = d; i.s1 = s1; i.s2 = s2; i.we = 1'b1; i.imm = imm; i.immv = immv;
    return i;
  endfunction

  // One instruction presented until the stage lets it go; expectations from the model state
  task automatic run_instr(input instr_t i, input int unsigned ack_delay);
    logic [31:0] a, b, res, rdat;
    logic        exp_wb;
    @(negedge clk);
    drive(i);
    mem_ack   = ($urandom_range(0, 3) == 0);
    mem_rdata = $urandom;
    a = regs_m[i.s1];
    b = i.imm ? i.immv : regs_m[i.s2];
    #1;
    if (squash_left != 0) begin
      check("sq_stall", 32'(stall), 32'd0);
      check("sq_flush", 32'(flush), 32'd1);
      check("sq_pc_load", 32'(pc_load), 32'd0);
      @(posedge clk); #1;
      obs_wb_valid = wb_valid;
      check("sq_wb_valid", 32'(wb_valid), 32'd0);
      check("sq_mem_req", 32'(mem_req), 32'd0);
      squash_left--;
      return;
    end
    if (!(i.rd || i.wr)) begin
      res = i.pcn ? i.pc + 32'd1 : ref_alu(i.op, a, b);
      exp_wb = i.we && (i.d != 5'd0);
      obs_pcl_val = pc_load_val;
      check("stall", 32'(stall), 32'd0);
      check("flush", 32'(flush), 32'(i.lpc));
      check("pc_load", 32'(pc_load), 32'(i.lpc));
      if (i.lpc) check("pc_load_val", pc_load_val, i.nxt ? a : i.lpcv);
      @(posedge clk); #1;
      obs_wb_valid = wb_valid; obs_wb_dest = wb_dest; obs_wb_data = wb_data;
      check("wb_valid", 32'(wb_valid), 32'(exp_wb));
      if (exp_wb) begin
        check("wb_dest", 32'(wb_dest), 32'(i.d));
        check("wb_data", wb_data, res);
        regs_m[i.d] = res;
      end
      if (i.lpc) squash_left = FLUSH_CYCLES - 1;
      return;
    end
    check("mem_issue_stall", 32'(stall), 32'd1);
    check("mem_issue_pc_load", 32'(pc_load), 32'd0);
    check("mem_issue_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    check("mem_issue_wb", 32'(wb_valid), 32'd0);
    rdat = 32'd0;
    for (int k = 0; k <= int'(ack_delay); k++) begin
      @(negedge clk);
      mem_ack   = (k == int'(ack_delay));
      mem_rdata = $urandom;
      rdat      = mem_rdata;
      #1;
      obs_mem_addr = mem_addr;
      check("mem_req", 32'(mem_req), 32'd1);
      check("mem_addr", mem_addr, a + b);
      check("mem_we", 32'(mem_we), 32'(i.wr));
      check("mem_wdata", mem_wdata, regs_m[i.s2]);
      check("mem_stall", 32'(stall), 32'(!mem_ack));
    end
    @(posedge clk); #1;
    exp_wb = i.rd && !i.wr && i.we && (i.d != 5'd0);
    obs_wb_valid = wb_valid; obs_wb_dest = wb_dest; obs_wb_data = wb_data;
    check("mem_done_req", 32'(mem_req), 32'd0);
    check("mem_wb_valid", 32'(wb_valid), 32'(exp_wb));
    if (exp_wb) begin
      check("mem_wb_dest", 32'(wb_dest), 32'(i.d));
      check("mem_wb_data", wb_data, rdat);
      regs_m[i.d] = rdat;
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) regs_m[r] = 32'd0;
    squash_left = 0;
  endtask

  instr_t ins;

  initial begin
    rst_n = 1'b0;
    ins = '0;
    drive(ins);
    mem_ack = 1'b0; mem_rdata = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_pc_load", 32'(pc_load), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed scenarios
    run_instr(mk_alu(4'd0, 5'd1, 5'd0, 5'd0, 1'b1, 32'd5), 0);
    run_instr(mk_alu(4'd0, 5'd2, 5'd0, 5'd0, 1'b1, 32'd7), 0);
    run_instr(mk_alu(4'd0, 5'd3, 5'd1, 5'd2, 1'b0, 32'd0), 0);
    check("add_12", obs_wb_data, 32'd12);
    check("add_dest", 32'(obs_wb_dest), 32'd3);
    run_instr(mk_alu(4'd1, 5'd4, 5'd3, 5'd1, 1'b0, 32'd0), 0);
    check("sub_7", obs_wb_data, 32'd7);

    ins = mk_alu(4'd0, 5'd4, 5'd1, 5'd0, 1'b1, 32'd8);
    ins.rd = 1'b1; ins.din = 1'b1;
    run_instr(ins, 2);
    check("ld_addr_13", obs_mem_addr, 32'd13);

    ins = '0; ins.lpc = 1'b1; ins.lpcv = 32'h40;
    run_instr(ins, 0);
    check("jmp_target", obs_pcl_val, 32'h40);
    run_instr(mk_alu(4'd0, 5'd5, 5'd1, 5'd1, 1'b0, 32'd0), 0);
    check("jmp_squashed", 32'(obs_wb_valid), 32'd0);
    run_instr(mk_alu(4'd0, 5'd5, 5'd1, 5'd1, 1'b0, 32'd0), 0);
    check("post_flush_add", obs_wb_data, 32'd10);

    ins = '0; ins.lpc = 1'b1; ins.lpcv = 32'h100; ins.pcn = 1'b1; ins.we = 1'b1;
    ins.d = 5'd31; ins.pc = 32'h20;
    run_instr(ins, 0);
    check("call_target", obs_pcl_val, 32'h100);
    check("call_link", obs_wb_data, 32'h21);
    ins = '0;
    run_instr(ins, 0);
    ins = '0; ins.lpc = 1'b1; ins.nxt = 1'b1; ins.s1 = 5'd31;
    run_instr(ins, 0);
    check("ret_target", obs_pcl_val, 32'h21);
    ins = '0;
    run_instr(ins, 0);

    run_instr(mk_alu(4'd0, 5'd0, 5'd1, 5'd1, 1'b0, 32'd0), 0);
    run_instr(mk_alu(4'd0, 5'd6, 5'd0, 5'd0, 1'b0, 32'd0), 0);
    check("r0_zero", obs_wb_data, 32'd0);
    run_instr(mk_alu(4'd13, 5'd7, 5'd1, 5'd2, 1'b0, 32'd0), 0);
    check("op13_zero", obs_wb_data, 32'd0);
    run_instr(mk_alu(4'd8, 5'd8, 5'd0, 5'd0, 1'b1, 32'h8000_0000), 0);
    run_instr(mk_alu(4'd7, 5'd9, 5'd8, 5'd0, 1'b1, 32'd4), 0);
    check("sra", obs_wb_data, 32'hF800_0000);

    ins = mk_alu(4'd0, 5'd10, 5'd1, 5'd2, 1'b1, 32'd4);
    ins.rd = 1'b1; ins.wr = 1'b1; ins.lpc = 1'b1;
    run_instr(ins, 1);
    check("store_no_wb", 32'(obs_wb_valid), 32'd0);

    // Reset asserted in the middle of an access
    ins = mk_alu(4'd0, 5'd11, 5'd1, 5'd0, 1'b1, 32'd4);
    ins.rd = 1'b1;
    @(negedge clk);
    drive(ins);
    mem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    check("pre_rst_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    ins = '0;
    drive(ins);
    #1;
    check("rst_mid_req", 32'(mem_req), 32'd0);
    check("rst_mid_wb", 32'(wb_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_rel_wb", 32'(wb_valid), 32'd0);
    run_instr(mk_alu(4'd0, 5'd3, 5'd1, 5'd2, 1'b0, 32'd0), 0);
    check("rst_regs_zero", obs_wb_data, 32'd0);

    // Randomized instruction stream
    for (int n = 0; n < 400; n++) begin
      int unsigned kind;
      ins = '0;
      ins.op   = 4'($urandom_range(0, 15));
      ins.s1   = 5'($urandom_range(0, 31));
      ins.s2   = 5'($urandom_range(0, 31));
      ins.d    = 5'($urandom_range(0, 31));
      ins.we   = ($urandom_range(0, 3) != 0);
      ins.imm  = 1'($urandom_range(0, 1));
      ins.immv = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom;
      ins.pc   = $urandom;
      ins.lpcv = $urandom;
      kind = $urandom_range(0, 11);
      case (kind)
        0: begin ins.rd = 1'b1; ins.din = 1'b1; end
        1: ins.wr = 1'b1;
        2: begin ins.rd = 1'b1; ins.wr = 1'b1; ins.lpc = 1'(($urandom_range(0, 1))); end
        3: ins.lpc = 1'b1;
        4: begin ins.lpc = 1'b1; ins.nxt = 1'b1; end
        5: begin ins.lpc = 1'b1; ins.pcn = 1'b1; end
        6: ins.pcn = 1'b1;
        default: ;
      endcase
      run_instr(ins, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
